// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: byte width, default sizing,
// word-width helper and the FSM state encoding.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN adds the CHECK state.
package program_loader_pkg;

  localparam int BYTE_W       = 8;
  localparam int DEFAULT_STEP = 4;
  localparam int DEFAULT_IAW  = 20;
  localparam int WORD_W       = DEFAULT_STEP * BYTE_W;

  function automatic int word_width(input int step);
    return step * BYTE_W;
  endfunction

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a byte stream little-endian into one instruction word.
// The word output already includes the byte being strobed this cycle, so
// the owner can register the complete word on the last byte's edge.
module word_assembler
  import program_loader_pkg::*;
#(
  parameter int STEP = DEFAULT_STEP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      strobe,
  input  logic [BYTE_W-1:0]         byte_in,
  output logic [STEP*BYTE_W-1:0]    word,
  output logic                      last_byte
);

  localparam int WW    = word_width(STEP);
  localparam int IDX_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEP - 1);

  logic [IDX_W-1:0] idx;
  logic [WW-1:0]    word_q;
  logic [WW-1:0]    word_ins;

  // Current word with the incoming byte dropped into lane idx
  always_comb begin
    word_ins = word_q;
    word_ins[idx*BYTE_W +: BYTE_W] = byte_in;
  end

  // Lane register and index; clear wins over a simultaneous strobe
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx    <= '0;
      word_q <= '0;
    end else if (strobe) begin
      word_q <= word_ins;
      idx    <= last_byte ? '0 : idx + 1'b1;
    end
  end

  assign word      = strobe ? word_ins : word_q;
  assign last_byte = (idx == LAST_IDX);

endmodule

// File: rtl/program_loader.sv
// Program loader: byte stream in, one pgm write per packed word out,
// holding the core for the whole session.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum byte
// compared against the 8-bit sum of the payload; mismatch raises err.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INSTR_ADDR_WIDTH = DEFAULT_IAW,
  parameter int STEP             = DEFAULT_STEP
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [INSTR_ADDR_WIDTH-1:0] base_addr,
  input  logic [INSTR_ADDR_WIDTH:0]   word_count,
  input  logic [BYTE_W-1:0]           rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic                        pgm,
  output logic [INSTR_ADDR_WIDTH-1:0] addr,
  output logic [STEP*BYTE_W-1:0]      data,
  output logic                        busy,
  output logic                        done,
  output logic                        cpu_hold,
  output logic                        err
);

  localparam int WW = word_width(STEP);
  localparam logic [INSTR_ADDR_WIDTH:0] ONE_LEFT = (INSTR_ADDR_WIDTH+1)'(1);

  state_t                      state;
  logic [INSTR_ADDR_WIDTH-1:0] cur_addr;
  logic [INSTR_ADDR_WIDTH:0]   remaining;
  logic                        byte_accept;
  logic                        asm_clear;
  logic [WW-1:0]               asm_word;
  logic                        asm_last;

  assign byte_accept = (state == ST_COLLECT) && rx_valid;
  assign asm_clear   = (state == ST_IDLE) || (state == ST_WRITE);

  word_assembler #(.STEP(STEP)) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (asm_clear),
    .strobe    (byte_accept),
    .byte_in   (rx_data),
    .word      (asm_word),
    .last_byte (asm_last)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum;
  logic              err_q;

  assign rx_ready = (state == ST_COLLECT) || (state == ST_CHECK);
  assign busy     = (state == ST_COLLECT) || (state == ST_WRITE) || (state == ST_CHECK);
  assign err      = err_q;
`else
  assign rx_ready = (state == ST_COLLECT);
  assign busy     = (state == ST_COLLECT) || (state == ST_WRITE);
  assign err      = 1'b0;
`endif

  assign done     = (state == ST_DONE);
  assign cpu_hold = busy;

  // Session FSM with address/remaining counters and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      pgm       <= 1'b0;
      addr      <= '0;
      data      <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      pgm <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= word_count;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum       <= '0;
            err_q     <= 1'b0;
`endif
            state     <= (word_count == '0) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (byte_accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum <= sum + rx_data;
`endif
            if (asm_last) begin
              pgm   <= 1'b1;
              addr  <= cur_addr;
              data  <= asm_word;
              state <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          cur_addr  <= cur_addr + 1'b1;
          remaining <= remaining - 1'b1;
          if (remaining == ONE_LEFT) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state <= ST_CHECK;
`else
            state <= ST_DONE;
`endif
          end else begin
            state <= ST_COLLECT;
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_valid) begin
            err_q <= (rx_data != sum);
            state <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (IAW=20, STEP=4).
// Build with PROGRAM_LOADER_CHECKSUM_EN to exercise the checksum path.
module tb_program_loader;
  import program_loader_pkg::*;

  localparam int IAW = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [IAW-1:0]    base_addr;
  logic [IAW:0]      word_count;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              pgm;
  logic [IAW-1:0]    addr;
  logic [WORD_W-1:0] data;
  logic              busy;
  logic              done;
  logic              cpu_hold;
  logic              err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [IAW-1:0]    pq_addr[$];
  logic [WORD_W-1:0] pq_data[$];
  int                ready_bad = 0;
  logic [7:0]        exp_sum;

  program_loader #(.INSTR_ADDR_WIDTH(IAW), .STEP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .pgm        (pgm),
    .addr       (addr),
    .data       (data),
    .busy       (busy),
    .done       (done),
    .cpu_hold   (cpu_hold),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Record every write pulse and flag any pulse seen with rx_ready high
  always @(negedge clk) begin
    if (pgm === 1'b1) begin
      pq_addr.push_back(addr);
      pq_data.push_back(data);
      if (rx_ready !== 1'b0) ready_bad++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session(input logic [IAW-1:0] b, input logic [IAW:0] c);
    pq_addr.delete();
    pq_data.delete();
    exp_sum    = 8'h00;
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50 && !sent; i++) begin
      if (rx_ready === 1'b1) sent = 1;
      tick();
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    exp_sum  = exp_sum + b;
    if (!sent) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL send_byte timeout: rx_ready stayed %b, required 1", rx_ready);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(exp_sum);
    if (done === 1'b1) seen = 1;
`endif
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1;
      else tick();
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("[TB] FAIL wait_done timeout: done=%b required 1", done);
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    rx_data = 8'h00; rx_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({rx_ready, pgm, busy, done, cpu_hold, err} !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b required 000000", {rx_ready, pgm, busy, done, cpu_hold, err});
    end
    n_cmp++;
    if (addr !== '0 || data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_bus: addr=%h data=%h required 0/0", addr, data);
    end
  endtask

  task automatic test_single_word();
    start_session(20'h10, 21'd1);
    n_cmp++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_busy: busy=%b hold=%b ready=%b required 1/1/1", busy, cpu_hold, rx_ready);
    end
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h10);
    n_cmp++;
    if (pgm !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_early_pgm: pgm=%b required 0", pgm);
    end
    send_byte(8'h00);
    n_cmp++;
    if (pgm !== 1'b1 || addr !== 20'h10 || data !== 32'h00100513 || rx_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_write: pgm=%b addr=%h data=%h ready=%b required 1/00010/00100513/0", pgm, addr, data, rx_ready);
    end
    n_cmp++;
    if (cpu_hold !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL single_hold: cpu_hold=%b required 1", cpu_hold);
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    tick();
    send_byte(8'h28);
`else
    tick();
`endif
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || pgm !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_done: done=%b busy=%b pgm=%b err=%b required 1/0/0/0", done, busy, pgm, err);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || addr !== 20'h10 || data !== 32'h00100513) begin
      n_fail++;
      $display("[TB] FAIL single_after: done=%b addr=%h data=%h required 0/00010/00100513", done, addr, data);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'hA3A2A1A0;
    exp_w[1] = 32'hA7A6A5A4;
    exp_w[2] = 32'hABAAA9A8;
    ready_bad = 0;
    start_session(20'd5, 21'd3);
    for (int i = 0; i < 12; i++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
      send_byte(8'hA0 + 8'(i));
    end
    wait_done();
    n_cmp++;
    if (pq_addr.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL bp_count: got %0d pulses required 3", pq_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (pq_addr[i] !== IAW'(5 + i) || pq_data[i] !== exp_w[i]) begin
          n_fail++;
          $display("[TB] FAIL bp_word%0d: addr=%h data=%h required %h/%h", i, pq_addr[i], pq_data[i], 5 + i, exp_w[i]);
        end
      end
    end
    n_cmp++;
    if (ready_bad != 0) begin
      n_fail++;
      $display("[TB] FAIL bp_ready_in_write: %0d pulses with rx_ready high, required 0", ready_bad);
    end
  endtask

  task automatic test_wrap_and_zero();
    start_session(20'hFFFFF, 21'd2);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    wait_done();
    n_cmp++;
    if (pq_addr.size() != 2 || pq_addr[0] !== 20'hFFFFF || pq_addr[1] !== 20'h00000 ||
        pq_data[0] !== 32'h04030201 || pq_data[1] !== 32'h08070605) begin
      n_fail++;
      $display("[TB] FAIL wrap: n=%0d first=%h/%h second=%h/%h required FFFFF/04030201 00000/08070605",
               pq_addr.size(), pq_addr[0], pq_data[0], pq_addr[1], pq_data[1]);
    end
    start_session(20'h3, 21'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL zero_done: done=%b busy=%b required 1/0", done, busy);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || pq_addr.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL zero_after: done=%b pulses=%0d required 0/0", done, pq_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    start_session(20'h40, 21'd1);
    send_byte(8'hEE); send_byte(8'hDD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if ({rx_ready, pgm, busy, done, cpu_hold, err} !== 6'b0 || addr !== '0 || data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: ctrl=%b addr=%h data=%h required 0", {rx_ready, pgm, busy, done, cpu_hold, err}, addr, data);
    end
    tick();
    n_cmp++;
    if (pq_addr.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_pgm: %0d pulses required 0", pq_addr.size());
    end
    start_session(20'h41, 21'd1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_done();
    n_cmp++;
    if (pq_addr.size() != 1 || pq_addr[0] !== 20'h41 || pq_data[0] !== 32'h44332211) begin
      n_fail++;
      $display("[TB] FAIL reset_fresh: n=%0d addr=%h data=%h required 1/00041/44332211", pq_addr.size(), pq_addr[0], pq_data[0]);
    end
  endtask

  task automatic test_start_busy();
    start_session(20'h100, 21'd2);
    send_byte(8'h01);
    base_addr  = 20'h200;
    word_count = 21'd5;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    for (int i = 2; i <= 8; i++) send_byte(8'(i));
    wait_done();
    n_cmp++;
    if (pq_addr.size() != 2 || pq_addr[0] !== 20'h100 || pq_addr[1] !== 20'h101 ||
        pq_data[0] !== 32'h04030201 || pq_data[1] !== 32'h08070605) begin
      n_fail++;
      $display("[TB] FAIL start_busy: n=%0d a0=%h a1=%h required 2/00100/00101", pq_addr.size(), pq_addr[0], pq_addr[1]);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_busy_idle: busy=%b required 0", busy);
    end
  endtask

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    start_session(20'h20, 21'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0A);
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL csum_good: done=%b err=%b required 1/0", done, err);
    end
    tick();
    start_session(20'h20, 21'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h0B);
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL csum_bad: done=%b err=%b required 1/1", done, err);
    end
    tick(); tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL csum_sticky: err=%b required 1", err);
    end
    start_session(20'h0, 21'd0);
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL csum_clear: err=%b required 0", err);
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_wrap_and_zero();
    test_reset_mid();
    test_start_busy();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
